washer_phase_timer: RTL
=======================

// Module: washer_phase_timer
// PURPOSE
//  Parametrised phase timer for the wash machine controller FSM. Replaces the fixed 4-bit timer.
//  - Counts elapsed ticks since the controller's restart (R).
//  - Raises phase-expiry flags Td/Tf/Tr/Ts/Tw at programmable thresholds.
//  - Adds: honoured hold (pause), saturation instead of wrap, load latched at restart, a 4th load size.
// PARAMETERS
//  CNT_W      8   counter width in bits; max count CMAX = 2**CNT_W-1
//  T_DRAIN    1   count at which Td asserts
//  T_FILL     2   count at which Tf asserts
//  T_RINSE    4   count at which Tr asserts
//  T_SPIN     7   count at which Ts asserts
//  T_WASH_S   2   Tw threshold, load 2'b00 (small)
//  T_WASH_M   4   Tw threshold, load 2'b01 (medium)
//  T_WASH_L   8   Tw threshold, load 2'b10 (large)
//  T_WASH_XL  12  Tw threshold, load 2'b11 (extra-large)
//  PRESCALE   4   clk cycles per tick; used only with WASHER_PRESCALE_EN
//  Legality: every T_* in 1..CMAX, PRESCALE>=1; otherwise elaboration error ($error in generate).
// PORTS
//  clk    in   1      single clock, all state on posedge
//  R      in   1      synchronous, active-high reset/restart; also latches load
//  hold   in   1      1 = freeze timer (count and prescaler); R overrides
//  load   in   2      load size: 00 S, 01 M, 10 L, 11 XL
//  Td     out  1      count == T_DRAIN
//  Tf     out  1      count == T_FILL
//  Tr     out  1      count == T_RINSE
//  Ts     out  1      count == T_SPIN
//  Tw     out  1      count == wash threshold of latched load
//  count  out  CNT_W  current elapsed tick count
//  sat    out  1      count == CMAX
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high on R.
//  - R=1 at a posedge: count<=0, load_q<=load, prescaler<=0. R has priority over hold.
//  - Reset values: count=0, sat=0, Td=Tf=Tr=Ts=Tw=0, since all thresholds are >=1.
//  - Otherwise, at each posedge:
//    - hold=1: all state holds.
//    - hold=0 and tick=1 and count<CMAX: count<=count+1.
//    - count==CMAX: count holds (saturates, never wraps).
//  - Outputs: combinational decode of registered count/load_q, no extra latency.
//    - A flag is high from the cycle after count reaches its threshold until count moves on.
//    - Under hold a flag stays high for the whole hold.
//  - Equal thresholds assert simultaneously (e.g. defaults: Tf and Tw(S) both at 2).
//  - load changes between restarts are ignored; Tw uses load_q only.
//  - R asserted mid-count: the next cycle is count=0 with all flags low, whatever the state.
//  - Width rule: T_* compared at CNT_W bits; increment is an unsigned CNT_W-bit add guarded by the saturation check.
// CONFIGURATION
//  - Macro WASHER_PRESCALE_EN defined: tick comes from washer_tick_gen.
//    - tick pulses 1 cycle every PRESCALE un-held cycles.
//    - Prescaler counter cleared by R and frozen by hold.
//    - PRESCALE=1 gives tick every cycle.
//  - Macro undefined: tick=1'b1 constant, PRESCALE ignored, no prescaler flops.
// STRUCTURE
//  - Package washer_pkg: load encodings (LOAD_S/M/L/XL) and default threshold localparams.
//    The controller FSM shares this package.
//  - Sub-module washer_tick_gen (clk, R, hold -> tick): instantiated only under WASHER_PRESCALE_EN.
//  - Top: count register, load_q register, threshold mux for Tw, output decode.
// TESTING
//  1. R=1 for 2 cycles, then release with hold=0, load=01.
//     -> count 0,1,2,...; Td at count 1, Tf at 2, Tr and Tw at 4, Ts at 7, each 1 cycle.
//  2. Hold at count=2 for 5 cycles. -> count stays 2, Tf high all 5 cycles, resumes to 3 on release.
//  3. load=11 latched, load changed to 00 at count 1. -> Tw only at count 12; no Tw at count 2.
//  4. CNT_W=4, run 20 cycles. -> count saturates at 15 with sat=1; no wrap, no flag re-assertion.
//  5. R=1 and hold=1 together at count=6. -> next cycle count=0, all flags 0.
//  6. WASHER_PRESCALE_EN with PRESCALE=4. -> count increments every 4 clk; Td first at clk 4 after release.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared encodings and default phase thresholds for the wash controller and its phase timer.
package washer_pkg;

  typedef enum logic [1:0] {
    LOAD_S  = 2'b00,
    LOAD_M  = 2'b01,
    LOAD_L  = 2'b10,
    LOAD_XL = 2'b11
  } load_e;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_T_DRAIN   = 1;
  localparam int DEF_T_FILL    = 2;
  localparam int DEF_T_RINSE   = 4;
  localparam int DEF_T_SPIN    = 7;
  localparam int DEF_T_WASH_S  = 2;
  localparam int DEF_T_WASH_M  = 4;
  localparam int DEF_T_WASH_L  = 8;
  localparam int DEF_T_WASH_XL = 12;
  localparam int DEF_PRESCALE  = 4;

endpackage

// File: rtl/washer_tick_gen.sv
// Tick prescaler: one-cycle tick every PRESCALE un-held clk cycles; cleared by R, frozen by hold.
module washer_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic R,
  input  logic hold,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // With PRESCALE=1, LAST is 0 and the counter never leaves 0, so tick is constant high.
  assign tick  = (pre_q == LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk) begin
    if (R)          pre_q <= '0;
    else if (!hold) pre_q <= pre_d;
  end

endmodule

// File: rtl/washer_phase_timer.sv
// Saturating phase timer with hold and restart-latched load size.
// Optional tick prescaler enabled by defining WASHER_PRESCALE_EN.
module washer_phase_timer
  import washer_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_DRAIN   = DEF_T_DRAIN,
  parameter int T_FILL    = DEF_T_FILL,
  parameter int T_RINSE   = DEF_T_RINSE,
  parameter int T_SPIN    = DEF_T_SPIN,
  parameter int T_WASH_S  = DEF_T_WASH_S,
  parameter int T_WASH_M  = DEF_T_WASH_M,
  parameter int T_WASH_L  = DEF_T_WASH_L,
  parameter int T_WASH_XL = DEF_T_WASH_XL,
  parameter int PRESCALE  = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             R,
  input  logic             hold,
  input  logic [1:0]       load,
  output logic             Td,
  output logic             Tf,
  output logic             Tr,
  output logic             Ts,
  output logic             Tw,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] CMAX_C = CNT_W'(CMAX);

  if (T_DRAIN  < 1 || T_DRAIN  > CMAX || T_FILL   < 1 || T_FILL   > CMAX ||
      T_RINSE  < 1 || T_RINSE  > CMAX || T_SPIN   < 1 || T_SPIN   > CMAX ||
      T_WASH_S < 1 || T_WASH_S > CMAX || T_WASH_M < 1 || T_WASH_M > CMAX ||
      T_WASH_L < 1 || T_WASH_L > CMAX || T_WASH_XL < 1 || T_WASH_XL > CMAX ||
      PRESCALE < 1) begin : g_bad_params
    $error("washer_phase_timer: threshold outside 1..CMAX or PRESCALE < 1");
  end

  logic tick;

`ifdef WASHER_PRESCALE_EN
  washer_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .R    (R),
    .hold (hold),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  logic [CNT_W-1:0] count_q, count_d;
  load_e            load_q;
  logic [CNT_W-1:0] wash_thr;

  assign count_d = (tick && count_q != CMAX_C) ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (R) begin
      count_q <= '0;
      load_q  <= load_e'(load);
    end else if (!hold) begin
      count_q <= count_d;
    end
  end

  always_comb begin
    wash_thr = CNT_W'(T_WASH_S);
    unique case (load_q)
      LOAD_S:  wash_thr = CNT_W'(T_WASH_S);
      LOAD_M:  wash_thr = CNT_W'(T_WASH_M);
      LOAD_L:  wash_thr = CNT_W'(T_WASH_L);
      LOAD_XL: wash_thr = CNT_W'(T_WASH_XL);
      default: wash_thr = CNT_W'(T_WASH_S);
    endcase
  end

  // Flags decode the registered count directly; thresholds are all >= 1 so they are low after R.
  assign Td    = (count_q == CNT_W'(T_DRAIN));
  assign Tf    = (count_q == CNT_W'(T_FILL));
  assign Tr    = (count_q == CNT_W'(T_RINSE));
  assign Ts    = (count_q == CNT_W'(T_SPIN));
  assign Tw    = (count_q == wash_thr);
  assign sat   = (count_q == CMAX_C);
  assign count = count_q;

endmodule
